// File: rtl/present_pkg.sv
// rtl/present_pkg.sv - PRESENT-80 key schedule constants, FSM states and step helpers
package present_pkg;

  localparam int KEY_W = 80;
  localparam int RK_W  = 64;
  localparam int CNT_W = 5;
  localparam int IDX_W = 6;

  // Nibble i of each table sits at bits [(15-i)*4 +: 4] (entry 0 is the leftmost hex digit).
  localparam logic [63:0] SBOX     = 64'hC56B90AD3EF84712;
  localparam logic [63:0] SBOX_INV = 64'h5EF8C12DB463079A;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_SERVE  = 2'd2
  } ks_state_e;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SBOX[(4'd15 - x) * 4 +: 4];
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    return SBOX_INV[(4'd15 - x) * 4 +: 4];
  endfunction

  // Key bit 0 (MSB in the PRESENT numbering) is bit 79 here, so the
  // counter field k[60:64] lands on [19:15] and the S-box nibble on [79:76].
  function automatic logic [KEY_W-1:0] fwd_step(input logic [KEY_W-1:0] k,
                                                input logic [CNT_W-1:0] c);
    logic [KEY_W-1:0] r;
    r          = {k[18:0], k[79:19]};
    r[79:76]   = sbox(r[79:76]);
    r[19:15]   = r[19:15] ^ c;
    return r;
  endfunction

  // First half of the inverse step: undo the counter injection.
  function automatic logic [KEY_W-1:0] inv_unxor(input logic [KEY_W-1:0] k,
                                                 input logic [CNT_W-1:0] c);
    logic [KEY_W-1:0] r;
    r        = k;
    r[19:15] = r[19:15] ^ c;
    return r;
  endfunction

  // Second half: drop in the inverse-substituted nibble and undo the rotation.
  function automatic logic [KEY_W-1:0] inv_unrot(input logic [KEY_W-1:0] r_in,
                                                 input logic [3:0] nib);
    logic [KEY_W-1:0] r;
    r        = r_in;
    r[79:76] = nib;
    return {r[60:0], r[79:61]};
  endfunction

endpackage

// File: rtl/present_sbox_inv.sv
// rtl/present_sbox_inv.sv - 4-bit combinational PRESENT inverse S-box
module present_sbox_inv
  import present_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Pure table lookup; kept as its own cell so the inverse path has one clear S-box instance.
  always_comb begin
    dout = sbox_inv(din);
  end

endmodule

// File: rtl/present_dec_key_sched.sv
// rtl/present_dec_key_sched.sv - PRESENT-80 decrypt-order round key scheduler (option: PRESENT_DK_SELFCHECK_EN)
module present_dec_key_sched
  import present_pkg::*;
#(
  parameter int ROUNDS = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_load,
  input  logic [79:0] key_in,
  output logic        busy,
  output logic        rk_valid,
  input  logic        rk_ready,
  output logic [63:0] rk,
  output logic [5:0]  rk_idx,
  output logic        err
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROUNDS);

  ks_state_e         state_q, state_d;
  logic [KEY_W-1:0]  kreg_q, kreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [KEY_W-1:0]  inv_pre;
  logic [3:0]        inv_nib;
  logic [KEY_W-1:0]  kreg_inv;
  logic              serving;
  logic              hs;

  assign serving = (state_q == ST_SERVE);
  assign hs      = serving & rk_ready;

  assign inv_pre = inv_unxor(kreg_q, cnt_q);

  present_sbox_inv u_sbox_inv (
    .din  (inv_pre[79:76]),
    .dout (inv_nib)
  );

  assign kreg_inv = inv_unrot(inv_pre, inv_nib);

  // Outputs are decoded from state so reset and IDLE both present all-zero outputs.
  always_comb begin
    busy     = (state_q != ST_IDLE);
    rk_valid = serving;
    rk       = serving ? kreg_q[79:16] : '0;
    rk_idx   = serving ? (IDX_W'(cnt_q) + IDX_W'(1)) : '0;
  end

  // Next-state: load in IDLE, forward-expand to the last key, then walk back one step per handshake.
  always_comb begin
    state_d = state_q;
    kreg_d  = kreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (key_load) begin
          kreg_d  = key_in;
          cnt_d   = CNT_W'(1);
          state_d = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        kreg_d = fwd_step(kreg_q, cnt_q);
        if (cnt_q == LAST_CNT) begin
          state_d = ST_SERVE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SERVE: begin
        if (hs) begin
          if (cnt_q != '0) begin
            kreg_d = kreg_inv;
            cnt_d  = cnt_q - CNT_W'(1);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, key and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      kreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      kreg_q  <= kreg_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PRESENT_DK_SELFCHECK_EN
  logic [KEY_W-1:0] shadow_q;
  logic             err_q;

  // Remember the master key and flag a sticky error if the walk-back does not land on it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if ((state_q == ST_IDLE) && key_load) begin
        shadow_q <= key_in;
      end
      if (hs && (cnt_q == '0) && (kreg_q != shadow_q)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_present_dec_key_sched.sv
// tb/tb_present_dec_key_sched.sv - randomized self-checking bench for present_dec_key_sched
module tb_present_dec_key_sched;

  localparam int ROUNDS = 31;
  localparam int NKEYS  = ROUNDS + 1;

  logic        clk;
  logic        rst_n;
  logic        key_load;
  logic [79:0] key_in;
  logic        busy;
  logic        rk_valid;
  logic        rk_ready;
  logic [63:0] rk;
  logic [5:0]  rk_idx;
  logic        err;

  int n_checks;
  int n_fail;

  logic [63:0] exp_rk [1:NKEYS];
  int          sbox_t [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

  present_dec_key_sched #(.ROUNDS(ROUNDS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_load (key_load),
    .key_in   (key_in),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk       (rk),
    .rk_idx   (rk_idx),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: textbook PRESENT-80 update (rotate left 61, S-box top nibble, counter into bits 19..15).
  function automatic logic [79:0] model_update(input logic [79:0] k, input int c);
    logic [79:0] r;
    int          top;
    r = (k << 61) | (k >> 19);
    top = int'(r[79:76]);
    r[79:76] = 4'(sbox_t[top]);
    r = r ^ (80'(c) << 15);
    return r;
  endfunction

  task automatic build_model(input logic [79:0] key);
    logic [79:0] k;
    k = key;
    for (int i = 1; i <= NKEYS; i++) begin
      exp_rk[i] = k[79:16];
      k = model_update(k, i);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check({tag, "_busy"},  busy,     80'd0);
    check({tag, "_valid"}, rk_valid, 80'd0);
    check({tag, "_rk"},    rk,       80'd0);
    check({tag, "_idx"},   rk_idx,   80'd0);
    @(posedge clk); #1;
  endtask

  // Pulse key_load, then wait for the first round key; optionally retry a load mid-expansion.
  task automatic load_and_wait(input logic [79:0] key, input bit ign_load);
    int lat;
    build_model(key);
    key_in   = key;
    key_load = 1'b1;
    @(posedge clk); #1;
    key_load = 1'b0;
    lat = 1;
    while (!rk_valid && lat < 200) begin
      rk_ready = 1'($urandom_range(0, 1));
      if (ign_load && lat == 5) begin
        key_load = 1'b1;
        key_in   = ~key;
      end
      if (lat == 10) begin
        check("expand_busy", busy, 80'd1);
      end
      @(posedge clk); #1;
      key_load = 1'b0;
      key_in   = key;
      lat++;
    end
    check("latency", lat, 80'(ROUNDS + 1));
  endtask

  // Consume round keys with random stalls; stop early (before accepting stop_idx) when stop_idx > 0.
  task automatic serve(input logic [79:0] key, input int max_stall, input int stop_idx, input bit ign_load);
    int idx;
    int guard;
    int xfers;
    int stall;
    idx   = NKEYS;
    guard = 0;
    xfers = 0;
    stall = (max_stall > 0) ? $urandom_range(0, max_stall) : 0;
    while (idx >= 1 && idx != stop_idx && guard < 3000) begin
      guard++;
      if (stall > 0) begin
        rk_ready = 1'b0;
        stall--;
      end else begin
        rk_ready = 1'b1;
        stall = (max_stall > 0) ? $urandom_range(0, max_stall) : 0;
      end
      if (ign_load && ($urandom_range(0, 3) == 0 || idx == 1)) begin
        key_load = 1'b1;
        key_in   = ~key;
      end
      @(negedge clk);
      check("valid", rk_valid, 80'd1);
      check("idx",   rk_idx,   80'(idx));
      check("rk",    rk,       80'(exp_rk[idx]));
      check("busy",  busy,     80'd1);
      check("err",   err,      80'd0);
      if (idx == 1) check("idx1_key", rk, 80'(key[79:16]));
      if (key == 80'd0 && idx == 2) check("zero_idx2", rk, 80'(64'hC000_0000_0000_0000));
      @(posedge clk); #1;
      key_load = 1'b0;
      key_in   = key;
      if (rk_ready) begin
        idx--;
        xfers++;
      end
    end
    rk_ready = 1'b0;
    check("serve_timeout", 80'(guard < 3000), 80'd1);
    if (stop_idx == 0) begin
      check("xfers", xfers, 80'(NKEYS));
      check_idle("after_serve");
    end
  endtask

  initial begin
    logic [79:0] k;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    key_load = 1'b0;
    key_in   = '0;
    rk_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_err", err, 80'd0);
    @(posedge clk); #1;
    check_idle("reset");

    k = 80'd0;
    load_and_wait(k, 1'b0);
    serve(k, 0, 0, 1'b0);

    k = {80{1'b1}};
    load_and_wait(k, 1'b0);
    serve(k, 0, 0, 1'b0);

    for (int t = 0; t < 3; t++) begin
      k = {16'($urandom), $urandom, $urandom};
      load_and_wait(k, 1'b0);
      serve(k, 5, 0, 1'b0);
    end

    k = {16'($urandom), $urandom, $urandom};
    load_and_wait(k, 1'b1);
    serve(k, 3, 0, 1'b1);

    k = {16'($urandom), $urandom, $urandom};
    load_and_wait(k, 1'b0);
    serve(k, 2, 17, 1'b0);
    do_reset();
    check_idle("mid_reset");
    k = {16'($urandom), $urandom, $urandom};
    load_and_wait(k, 1'b0);
    serve(k, 2, 0, 1'b0);

`ifdef PRESENT_DK_SELFCHECK_EN
    begin
      logic [79:0] v;
      k = {16'($urandom), $urandom, $urandom};
      load_and_wait(k, 1'b0);
      rk_ready = 1'b1;
      repeat (15) @(posedge clk);
      #1;
      v = dut.kreg_q ^ 80'h1;
      force dut.kreg_q = v;
      #1;
      release dut.kreg_q;
      for (int g = 0; g < 100 && rk_valid; g++) begin
        @(posedge clk); #1;
      end
      rk_ready = 1'b0;
      @(negedge clk);
      check("selfcheck_err", err, 80'd1);
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("selfcheck_sticky", err, 80'd1);
      @(posedge clk); #1;
      do_reset();
      @(negedge clk);
      check("selfcheck_cleared", err, 80'd0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/present_dec_key_sched.md
Name: present_dec_key_sched

Overview:
Sequential PRESENT-80 decryption key scheduler, the inverse of the forward one-round key update used on the encrypt side.
- Takes the 80-bit master key and runs the forward schedule ROUNDS times to reach the final key register.
- Then walks the schedule backwards with the inverse update, one step per accepted handshake.
- Issues round keys in decrypt order (idx ROUNDS+1 down to 1) to the decryption datapath.

Parameters:
- ROUNDS, 31, number of forward update steps (1..31); round keys issued = ROUNDS+1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- key_load  in  1  start pulse; sampled only in IDLE
- key_in  in  80  master key, [0:79], bit 0 = MSB
- busy  out  1  high in EXPAND and SERVE
- rk_valid  out  1  round key available
- rk_ready  in  1  consumer accepts round key
- rk  out  64  round key = kreg[0:63]
- rk_idx  out  6  round index of rk (1..32)
- err  out  1  sticky self-check failure (see Optional Feature)

Behaviour:
- State: kreg[0:79], cnt[0:4], FSM {IDLE, EXPAND, SERVE}.
- Reset (rst_n=0 at clk edge, any state, including mid-operation): FSM=IDLE, kreg=0, cnt=0, busy=0, rk_valid=0, rk=0, rk_idx=0, err=0.
- IDLE:
  - key_load=1: kreg<=key_in, cnt<=1, go EXPAND.
  - Otherwise hold. key_load is ignored in every other state.
- Forward step fwd(K,c):
  - r={K[61:79],K[0:60]};
  - r[0:3]=S(r[0:3]);
  - r[60:64]^=c.
- EXPAND: each cycle kreg<=fwd(kreg,cnt). If cnt==ROUNDS, stay at cnt and go SERVE; else cnt<=cnt+1.
  - Latency: load at cycle 0 → rk_valid=1 at cycle ROUNDS+1 (32 by default).
- SERVE outputs:
  - rk_valid=1, rk=kreg[0:63], rk_idx=cnt+1.
  - rk and rk_idx are stable while rk_valid & !rk_ready.
- Inverse step inv(K,c):
  - r=K;
  - r[60:64]^=c;
  - r[0:3]=Sinv(r[0:3]);
  - result={r[19:79],r[0:18]}.
- SERVE handshake (rk_valid & rk_ready):
  - If cnt!=0: kreg<=inv(kreg,cnt), cnt<=cnt-1.
  - If cnt==0 (idx 1 accepted): go IDLE, rk_valid<=0. kreg then equals key_in.
- rk_ready with rk_valid=0: no effect.
- rk_valid never drops without a handshake, except on reset.
- key_load in the same cycle as the final handshake: ignored, because FSM is still SERVE.
- S = C56B90AD3EF84712. Sinv = 5EF8C12DB4630 79A (index 0..F).
- cnt is 5 bits. It never wraps: max is ROUNDS ≤ 31, min is 0.

Optional Feature:
- Macro: PRESENT_DK_SELFCHECK_EN.
- Defined:
  - An 80-bit shadow register captures key_in on accepted key_load.
  - On the idx-1 handshake, err<=1 if inv-restored kreg != shadow. err is sticky until reset.
- Undefined: no shadow register; err tied to 0.

Decomposition:
- Package present_pkg:
  - SBOX and SBOX_INV 16x4 constant tables
  - KEY_W=80, RK_W=64, CNT_W=5, IDX_W=6
  - FSM state enum
  - fwd/inv step functions
- One sub-module: present_sbox_inv (4-bit combinational inverse S-box), instantiated once in the inverse path.
- The forward path reuses the existing sbox module.

Test Plan:
- Zero key: key_in=0, rk_ready=1 throughout → rk_valid rises at cycle 32; 32 handshakes with idx 32,31,…,1; idx 2 rk=64'hC000_0000_0000_0000; idx 1 rk=0; then IDLE, busy=0.
- All-ones key: key_in=80'hFFFF_FFFF_FFFF_FFFF_FFFF → every rk matches the reference model reversed; idx 1 rk=64'hFFFF_FFFF_FFFF_FFFF.
- Backpressure: random rk_ready with 0–5 stall cycles → rk/rk_idx constant while stalled; no index skipped or repeated; exactly 32 transfers.
- Ignored load: key_load with a different key during EXPAND and SERVE → output sequence unchanged and still derived from the first key.
- Reset mid-SERVE at idx 17: pull rst_n low for one edge → next cycle all outputs 0, state IDLE; a new load then produces the full sequence from idx 32.
- PRESENT_DK_SELFCHECK_EN:
  - Normal run → err=0.
  - Force a kreg bit flip mid-SERVE → err=1 after the idx-1 handshake and stays 1 until rst_n.
